// File: rtl/prpg_pkg.sv
// Shared constants for the PRPG/MISR block: mode encoding, tap masks and legal widths.
package prpg_pkg;

    typedef enum logic {
        MODE_PRPG = 1'b0,
        MODE_MISR = 1'b1
    } mode_e;

    localparam int MAX_N = 32;

    // Maximal-length taps for the right-shifting Fibonacci form used by prpg_step.
    function automatic logic [MAX_N-1:0] tap_mask(input int n);
        case (n)
            4:       return 32'h0000_0003;
            8:       return 32'h0000_001D;
            16:      return 32'h0000_100B;
            32:      return 32'hC000_0401;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic bit legal_width(input int n);
        return (n == 4) || (n == 8) || (n == 16) || (n == 32);
    endfunction

endpackage

// File: rtl/prpg_if.sv
// Control/status bundle between a PRPG/MISR generator and its user.
interface prpg_if #(
    parameter int N = 4
);
    logic         load;
    logic         en;
    logic         mode;
    logic [N-1:0] din;
    logic [N-1:0] seed;
    logic [N-1:0] qout;
    logic         seq_bit;
    logic [N-1:0] ones_cnt;
    logic [N-1:0] period_len;
    logic [N-1:0] period_ones;
    logic         period_valid;
    logic         lockup;

    modport master (
        output load, en, mode, din, seed,
        input  qout, seq_bit, ones_cnt, period_len, period_ones, period_valid, lockup
    );

    modport slave (
        input  load, en, mode, din, seed,
        output qout, seq_bit, ones_cnt, period_len, period_ones, period_valid, lockup
    );
endinterface

// File: rtl/prpg_step.sv
// Combinational LFSR/MISR next state: right shift with XOR feedback, din folded in for MISR.
// Latency: zero (pure logic); backpressure: none.
module prpg_step
    import prpg_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] qout,
    input  mode_e        mode,
    input  logic [N-1:0] din,
    output logic [N-1:0] qout_next,
    output logic         fb
);
    localparam logic [MAX_N-1:0] TAP_FULL = tap_mask(N);
    localparam logic [N-1:0]     TAP      = TAP_FULL[N-1:0];

    logic [N-1:0] shifted;

    always_comb begin
        fb        = ^(qout & TAP);
        shifted   = {fb, qout[N-1:1]};
        qout_next = (mode == MODE_MISR) ? (shifted ^ din) : shifted;
    end
endmodule

// File: rtl/prpg_gen.sv
// PRPG/MISR generator with period length / ones statistics and PRPG lock-up flag.
// Latency: one cycle from en/load to every output; backpressure: none, steps only when en.
module prpg_gen
    import prpg_pkg::*;
#(
    parameter int N = 4
) (
    input  logic  clk,
    input  logic  rst,
    prpg_if.slave bus
);
    if (!legal_width(N)) begin : g_bad_width
        $error("prpg_gen: N must be 4, 8, 16 or 32");
    end

    logic [N-1:0] qout_q, qout_d;
    logic [N-1:0] start_q, start_d;
    mode_e        mode_q, mode_d;
    logic         seq_bit_q, seq_bit_d;
    logic [N-1:0] ones_cnt_q, ones_cnt_d;
    logic [N-1:0] step_cnt_q, step_cnt_d;
    logic [N-1:0] period_len_q, period_len_d;
    logic [N-1:0] period_ones_q, period_ones_d;
    logic         period_valid_q, period_valid_d;
    logic         lockup_q, lockup_d;

    logic [N-1:0] qout_next;
    logic         fb;
    logic         prpg_zero;

    prpg_step #(.N(N)) u_step (
        .qout      (qout_q),
        .mode      (mode_q),
        .din       (bus.din),
        .qout_next (qout_next),
        .fb        (fb)
    );

    // In PRPG mode the next state is {fb, qout[N-1:1]}, so all-zero needs only fb and the upper bits.
    assign prpg_zero = !fb && (qout_q[N-1:1] == '0);

    always_comb begin
        qout_d         = qout_q;
        start_d        = start_q;
        mode_d         = mode_q;
        seq_bit_d      = seq_bit_q;
        ones_cnt_d     = ones_cnt_q;
        step_cnt_d     = step_cnt_q;
        period_len_d   = period_len_q;
        period_ones_d  = period_ones_q;
        period_valid_d = 1'b0;
        lockup_d       = lockup_q;

        if (bus.load) begin
            mode_d     = mode_e'(bus.mode);
            qout_d     = bus.seed;
            start_d    = bus.seed;
            if ((bus.mode == MODE_PRPG) && (bus.seed == '0)) begin
                qout_d  = N'(1);
                start_d = N'(1);
            end
            seq_bit_d  = 1'b0;
            ones_cnt_d = '0;
            step_cnt_d = '0;
            lockup_d   = 1'b0;
        end else if (bus.en) begin
            seq_bit_d = qout_q[0];
            qout_d    = qout_next;
            if (mode_q == MODE_MISR) begin
                ones_cnt_d = ones_cnt_q + N'(qout_q[0]);
            end else begin
                // Zero is a fixed point of the PRPG step, so the state stays locked once reached.
                if (prpg_zero) begin
                    lockup_d = 1'b1;
                end
                if (qout_next == start_q) begin
                    period_len_d   = step_cnt_q + N'(1);
                    period_ones_d  = ones_cnt_q + N'(qout_q[0]);
                    period_valid_d = 1'b1;
                    ones_cnt_d     = '0;
                    step_cnt_d     = '0;
                end else begin
                    step_cnt_d = step_cnt_q + N'(1);
                    ones_cnt_d = ones_cnt_q + N'(qout_q[0]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qout_q         <= N'(1);
            start_q        <= N'(1);
            mode_q         <= MODE_PRPG;
            seq_bit_q      <= 1'b0;
            ones_cnt_q     <= '0;
            step_cnt_q     <= '0;
            period_len_q   <= '0;
            period_ones_q  <= '0;
            period_valid_q <= 1'b0;
            lockup_q       <= 1'b0;
        end else begin
            qout_q         <= qout_d;
            start_q        <= start_d;
            mode_q         <= mode_d;
            seq_bit_q      <= seq_bit_d;
            ones_cnt_q     <= ones_cnt_d;
            step_cnt_q     <= step_cnt_d;
            period_len_q   <= period_len_d;
            period_ones_q  <= period_ones_d;
            period_valid_q <= period_valid_d;
            lockup_q       <= lockup_d;
        end
    end

    assign bus.qout         = qout_q;
    assign bus.seq_bit      = seq_bit_q;
    assign bus.ones_cnt     = ones_cnt_q;
    assign bus.period_len   = period_len_q;
    assign bus.period_ones  = period_ones_q;
    assign bus.period_valid = period_valid_q;
    assign bus.lockup       = lockup_q;
endmodule

// File: tb/tb_prpg_gen.sv
// Directed bench for prpg_gen at N=4, 8 and 16; expected values are hand-derived sequences.
module tb_prpg_gen;
    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    prpg_if #(.N(4))  if4  ();
    prpg_if #(.N(8))  if8  ();
    prpg_if #(.N(16)) if16 ();

    prpg_gen #(.N(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
    prpg_gen #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    prpg_gen #(.N(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int          seen;
        int          at;
        int          steps;
        int          pulses;
        logic [31:0] prev;

        rst = 1'b1;
        if4.load  = 1'b0; if4.en  = 1'b0; if4.mode  = 1'b0; if4.din  = '0; if4.seed  = '0;
        if8.load  = 1'b0; if8.en  = 1'b0; if8.mode  = 1'b0; if8.din  = '0; if8.seed  = '0;
        if16.load = 1'b0; if16.en = 1'b0; if16.mode = 1'b0; if16.din = '0; if16.seed = '0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_qout",   32'(if4.qout), 32'h1);
        chk("rst_seq",    32'(if4.seq_bit), 32'h0);
        chk("rst_ones",   32'(if4.ones_cnt), 32'h0);
        chk("rst_plen",   32'(if4.period_len), 32'h0);
        chk("rst_pones",  32'(if4.period_ones), 32'h0);
        chk("rst_pvalid", 32'(if4.period_valid), 32'h0);
        chk("rst_lockup", 32'(if4.lockup), 32'h0);
        chk("rst_qout16", 32'(if16.qout), 32'h1);
        rst = 1'b0;

        // N=4 seed 8: 8,4,2,9,C,6,B,5,A,D,E,F,7,3,1 -> 8
        if4.seed = 4'h8; if4.mode = 1'b0; if4.load = 1'b1;
        @(negedge clk);
        if4.load = 1'b0;
        chk("p20_load_qout", 32'(if4.qout), 32'h8);
        chk("p20_load_seq",  32'(if4.seq_bit), 32'h0);
        if4.en = 1'b1;
        seen = 0; at = 0;
        for (int i = 1; i <= 20 && seen == 0; i++) begin
            @(negedge clk);
            if (i == 1) chk("p20_step1_qout", 32'(if4.qout), 32'h4);
            if (i == 4) begin
                chk("p20_step4_qout", 32'(if4.qout), 32'hC);
                chk("p20_step4_seq",  32'(if4.seq_bit), 32'h1);
                chk("p20_step4_ones", 32'(if4.ones_cnt), 32'h1);
            end
            if (if4.period_valid) begin seen = 1; at = i; end
        end
        if4.en = 1'b0;
        chk("p20_pulse_step", 32'(at), 32'd15);
        chk("p20_plen",  32'(if4.period_len), 32'd15);
        chk("p20_pones", 32'(if4.period_ones), 32'd8);
        chk("p20_qout",  32'(if4.qout), 32'h8);
        chk("p20_ones_cleared", 32'(if4.ones_cnt), 32'h0);
        @(negedge clk);
        chk("p20_pulse_one_cycle", 32'(if4.period_valid), 32'h0);
        chk("p20_hold_qout", 32'(if4.qout), 32'h8);
        chk("p20_hold_plen", 32'(if4.period_len), 32'd15);

        // Zero seed in PRPG mode is replaced by 1
        if4.seed = 4'h0; if4.load = 1'b1;
        @(negedge clk);
        if4.load = 1'b0;
        chk("p22_load_qout", 32'(if4.qout), 32'h1);
        if4.en = 1'b1;
        seen = 0; at = 0;
        for (int i = 1; i <= 20 && seen == 0; i++) begin
            @(negedge clk);
            if (i == 1) chk("p22_step1_qout", 32'(if4.qout), 32'h8);
            if (if4.period_valid) begin seen = 1; at = i; end
        end
        if4.en = 1'b0;
        chk("p22_pulse_step", 32'(at), 32'd15);
        chk("p22_plen",   32'(if4.period_len), 32'd15);
        chk("p22_lockup", 32'(if4.lockup), 32'h0);
        chk("p22_qout",   32'(if4.qout), 32'h1);

        // MISR mode: zero state with zero data stays zero without lockup
        if4.seed = 4'h0; if4.mode = 1'b1; if4.din = 4'h0; if4.load = 1'b1;
        @(negedge clk);
        if4.load = 1'b0;
        chk("p23_load_qout", 32'(if4.qout), 32'h0);
        if4.en = 1'b1;
        seen = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("p23_zero_qout", 32'(if4.qout), 32'h0);
            if (if4.period_valid) seen = 1;
        end
        if4.din = 4'h5;
        @(negedge clk);
        chk("p23_din5_qout", 32'(if4.qout), 32'h5);
        if (if4.period_valid) seen = 1;
        if4.din = 4'h0;
        @(negedge clk);
        if (if4.period_valid) seen = 1;
        if4.en = 1'b0;
        chk("p23_next_qout", 32'(if4.qout), 32'hA);
        chk("p23_seq",       32'(if4.seq_bit), 32'h1);
        chk("p23_ones",      32'(if4.ones_cnt), 32'h1);
        chk("p23_lockup",    32'(if4.lockup), 32'h0);
        chk("p23_plen_hold", 32'(if4.period_len), 32'd15);
        chk("p23_no_pvalid", 32'(seen), 32'd0);

        // load wins over en, then en toggled on alternate cycles
        if4.seed = 4'h8; if4.mode = 1'b0; if4.load = 1'b1; if4.en = 1'b1;
        @(negedge clk);
        if4.load = 1'b0;
        chk("p25_load_qout", 32'(if4.qout), 32'h8);
        chk("p25_load_seq",  32'(if4.seq_bit), 32'h0);
        chk("p25_load_ones", 32'(if4.ones_cnt), 32'h0);
        seen = 0; steps = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            if4.en = (c % 2 == 0) ? 1'b1 : 1'b0;
            prev = 32'(if4.qout);
            @(negedge clk);
            if (if4.en) steps++;
            else chk("p25_hold_qout", 32'(if4.qout), prev);
            if (if4.period_valid) seen = 1;
        end
        if4.en = 1'b0;
        chk("p25_steps", 32'(steps), 32'd15);
        chk("p25_plen",  32'(if4.period_len), 32'd15);
        chk("p25_pones", 32'(if4.period_ones), 32'd8);

        // N=8 two full periods
        if8.seed = 8'h01; if8.mode = 1'b0; if8.load = 1'b1;
        @(negedge clk);
        if8.load = 1'b0;
        if8.en = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (if8.period_valid) begin
                pulses++;
                if (pulses == 1) chk("p21_first_step", 32'(i), 32'd255);
                else             chk("p21_second_step", 32'(i), 32'd510);
                chk("p21_plen",  32'(if8.period_len), 32'd255);
                chk("p21_pones", 32'(if8.period_ones), 32'd128);
            end
        end
        if8.en = 1'b0;
        chk("p21_pulses", 32'(pulses), 32'd2);

        // N=16: reset mid-period overrides load and en
        if16.seed = 16'h0001; if16.mode = 1'b0; if16.load = 1'b1;
        @(negedge clk);
        if16.load = 1'b0;
        if16.en = 1'b1;
        repeat (1000) @(negedge clk);
        rst = 1'b1; if16.load = 1'b1; if16.seed = 16'hBEEF; if16.mode = 1'b1;
        @(negedge clk);
        rst = 1'b0; if16.load = 1'b0; if16.en = 1'b0; if16.mode = 1'b0;
        chk("p24_rst_qout",   32'(if16.qout), 32'h1);
        chk("p24_rst_seq",    32'(if16.seq_bit), 32'h0);
        chk("p24_rst_ones",   32'(if16.ones_cnt), 32'h0);
        chk("p24_rst_plen",   32'(if16.period_len), 32'h0);
        chk("p24_rst_pones",  32'(if16.period_ones), 32'h0);
        chk("p24_rst_pvalid", 32'(if16.period_valid), 32'h0);
        chk("p24_rst_lockup", 32'(if16.lockup), 32'h0);
        chk("p24_rst_plen4",  32'(if4.period_len), 32'h0);
        if16.seed = 16'h0001; if16.load = 1'b1;
        @(negedge clk);
        if16.load = 1'b0;
        if16.en = 1'b1;
        seen = 0; at = 0;
        for (int i = 1; i <= 70000 && seen == 0; i++) begin
            @(negedge clk);
            if (if16.period_valid) begin seen = 1; at = i; end
        end
        if16.en = 1'b0;
        chk("p24_pulse_step", 32'(at), 32'd65535);
        chk("p24_plen",   32'(if16.period_len), 32'hFFFF);
        chk("p24_pones",  32'(if16.period_ones), 32'h8000);
        chk("p24_qout",   32'(if16.qout), 32'h1);
        chk("p24_lockup", 32'(if16.lockup), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/prpg_gen.md
PRPG_GEN -- requirements
Module: prpg_gen

Interface
REQ-001 SHALL have parameter N, default 4, meaning register width; legal values 4, 8, 16, 32; any other value is an elaboration error.
REQ-002 SHALL have ports:
- clk  in  1  single clock; one clock, all logic on rising edge.
- rst  in  1  reset; synchronous and active-high.
- load  in  1  capture seed and mode.
- en  in  1  advance one step.
- mode  in  1  0 = PRPG, 1 = MISR; sampled only on load.
- din  in  N  MISR compression data.
- seed  in  N  initial state.
- qout  out  N  current register state.
- seq_bit  out  1  bit shifted out on the last enabled step.
- ones_cnt  out  N  running count of 1s in seq_bit since period start.
- period_len  out  N  step count of the last completed period.
- period_ones  out  N  count of 1s in the last completed period.
- period_valid  out  1  one-cycle pulse: period_len and period_ones updated.
- lockup  out  1  sticky: all-zero state reached in PRPG mode.

Function
REQ-003 Step, PRPG mode: qout_next = {fb, qout[N-1:1]}; fb = XOR-reduce(qout & TAP[N]).
REQ-004 Step, MISR mode: qout_next = {fb, qout[N-1:1]} ^ din.
REQ-005 TAP masks SHALL be: N=4 4'h3; N=8 8'h1D; N=16 16'h100B; N=32 32'hC0000401. Each is maximal length, period 2^N-1.
REQ-006 Each enabled step SHALL register seq_bit <= qout[0].
REQ-007 On load: qout <= seed; captured start state <= seed; mode is latched; ones_cnt, step counter and lockup are cleared; seq_bit <= 0; period_valid <= 0.
REQ-008 On load with mode=0 and seed==0: qout and start state SHALL both be N'h1 instead.
REQ-009 load and en asserted together: load SHALL win and no step occurs.
REQ-010 en low and load low: every register holds; period_valid = 0.
REQ-011 PRPG step where qout_next != start: step counter +1; ones_cnt += qout[0]; period_valid <= 0.
REQ-012 PRPG step where qout_next == start (period completes):
- period_len <= step counter + 1.
- period_ones <= ones_cnt + qout[0].
- period_valid <= 1 for exactly one cycle.
- ones_cnt <= 0; step counter <= 0.
REQ-013 Counters SHALL be N bits. A maximal period gives len 2^N-1 and ones 2^(N-1), so neither overflows. A non-maximal case wraps modulo 2^N, with no error.
REQ-014 MISR mode:
- period detection is disabled; period_valid stays 0.
- period_len and period_ones hold.
- ones_cnt still counts seq_bit.
REQ-015 PRPG mode with qout==0 after a step: lockup <= 1 (sticky until load or rst), and the state SHALL hold at zero.
REQ-016 All outputs SHALL be registered, with one-cycle latency from the en edge.

Reset
REQ-017 rst=1 at a clock edge SHALL force the following, overriding load and en, including mid-period:
- qout = N'h1; start state = N'h1; mode = 0.
- seq_bit = 0; ones_cnt = 0; step counter = 0.
- period_len = 0; period_ones = 0.
- period_valid = 0; lockup = 0.

Structure
REQ-018 A shared package prpg_pkg SHALL hold the TAP mask function/table indexed by N and the mode encoding constants.
REQ-019 A single sub-module, prpg_step (combinational next-state: qout, mode, din -> qout_next, fb), SHALL be instantiated once. Counters, compare and flags live in prpg_gen.

Verification
REQ-020 N=4, load seed 4'h8 mode 0, en held -> period_valid pulses after the 15th step; period_len=15, period_ones=8; qout back to 4'h8.
REQ-021 N=8, seed 8'h01, en held for 600 cycles -> period_valid pulses at steps 255 and 510; each with period_len=255, period_ones=128.
REQ-022 N=4, load seed 4'h0 mode 0 -> qout=4'h1; the first period completes with period_len=15, lockup=0.
REQ-023 N=4, mode 1, seed 4'h0, din=4'h0 for 5 steps -> qout stays 0, lockup=0, period_valid never asserts. A then-din=4'h5 step gives qout=4'h5.
REQ-024 N=16, rst asserted at step 1000 with load and en also high -> next cycle all outputs at their reset values; a restart from seed 16'h1 completes the period at 65535 steps.
REQ-025 N=4, load and en high together, then en toggled 1/0 -> the load cycle does not step; held cycles keep qout constant; the period still reports 15 enabled steps.
